mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a single synchronous memory port.
// Round-robin with a 1-bit priority pointer; one access every two cycles at full load.
module mem_arbiter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [15:0] cpu_wdata_i,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [15:0] dma_addr_i,
    input  logic [15:0] dma_wdata_i,
    output logic        cpu_gnt_o,
    output logic        dma_gnt_o,
    output logic        cpu_done_o,
    output logic        dma_done_o,
    output logic [15:0] cpu_rdata_o,
    output logic [15:0] dma_rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StData} state_e;

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;  // 0 = CPU, 1 = DMA
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_gnt_q, cpu_gnt_d;
    logic        dma_gnt_q, dma_gnt_d;
    logic        cpu_done_q, cpu_done_d;
    logic        dma_done_q, dma_done_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;
    logic        busy_q, busy_d;

    logic any_req;
    logic cpu_win;
    logic arb_en;

    assign any_req = cpu_req_i | dma_req_i;
    // A lone requester wins; on contention the pointer decides.
    assign cpu_win = cpu_req_i & (~dma_req_i | ~prio_q);

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_gnt_d   = 1'b0;
        dma_gnt_d   = 1'b0;
        cpu_done_d  = 1'b0;
        dma_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        arb_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                arb_en = 1'b1;
            end
            StIssue: begin
                state_d = StData;
            end
            StData: begin
                state_d = StIdle;
                arb_en  = 1'b1;
                if (owner_q) begin
                    dma_done_d = 1'b1;
                end else begin
                    cpu_done_d = 1'b1;
                end
                // Read data returns while in DATA; writes leave rdata untouched.
                if (!mem_we_q) begin
                    if (owner_q) begin
                        dma_rdata_d = mem_rdata_i;
                    end else begin
                        cpu_rdata_d = mem_rdata_i;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (arb_en && any_req) begin
            state_d  = StIssue;
            owner_d  = ~cpu_win;
            prio_d   = cpu_win;
            mem_en_d = 1'b1;
            if (cpu_win) begin
                mem_we_d    = cpu_we_i;
                mem_addr_d  = cpu_addr_i;
                mem_wdata_d = cpu_wdata_i;
                cpu_gnt_d   = 1'b1;
            end else begin
                mem_we_d    = dma_we_i;
                mem_addr_d  = dma_addr_i;
                mem_wdata_d = dma_wdata_i;
                dma_gnt_d   = 1'b1;
            end
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            cpu_gnt_q   <= 1'b0;
            dma_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            cpu_rdata_q <= 16'h0000;
            dma_rdata_q <= 16'h0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_gnt_q   <= cpu_gnt_d;
            dma_gnt_q   <= dma_gnt_d;
            cpu_done_q  <= cpu_done_d;
            dma_done_q  <= dma_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_gnt_o   = cpu_gnt_q;
    assign dma_gnt_o   = dma_gnt_q;
    assign cpu_done_o  = cpu_done_q;
    assign dma_done_o  = dma_done_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

    a_no_back_to_back_en: assert property (
        @(posedge clk_i) disable iff (!rst_ni) mem_en_o |=> !mem_en_o);
    a_one_gnt: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(cpu_gnt_o && dma_gnt_o));
    a_one_done: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(cpu_done_o && dma_done_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level schedule model predicts each
// grant, memory access and completion; a behavioural memory answers the DUT's port.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, dma_gnt, cpu_done, dma_done;
    logic [15:0] cpu_rdata, dma_rdata;
    logic        mem_en, mem_we, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .dma_req_i   (dma_req),
        .dma_we_i    (dma_we),
        .dma_addr_i  (dma_addr),
        .dma_wdata_i (dma_wdata),
        .cpu_gnt_o   (cpu_gnt),
        .dma_gnt_o   (dma_gnt),
        .cpu_done_o  (cpu_done),
        .dma_done_o  (dma_done),
        .cpu_rdata_o (cpu_rdata),
        .dma_rdata_o (dma_rdata),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    // Device memory behind the DUT's port.
    bit [15:0] dev_mem [65536];
    bit        dev_wr  [65536];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                dev_mem[mem_addr] <= mem_wdata;
                dev_wr[mem_addr]  <= 1'b1;
            end else begin
                mem_rdata <= dev_wr[mem_addr] ? dev_mem[mem_addr] : init_val(mem_addr);
            end
        end
    end

    // Reference model state: independent memory image and a schedule of expected events.
    bit [15:0]   ref_mem [65536];
    bit          ref_wr  [65536];
    int          cyc;
    int          next_arb;
    int          last_arb;
    bit          m_prio;
    logic [15:0] exp_cpu_rdata, exp_dma_rdata;
    bit          e_cgnt [8];
    bit          e_dgnt [8];
    bit          e_en   [8];
    bit          e_we   [8];
    logic [15:0] e_addr [8];
    logic [15:0] e_wdata[8];
    bit          d_v    [8];
    bit          d_dma  [8];
    bit          d_rd   [8];
    logic [15:0] d_data [8];

    int          n_checks;
    int          n_errors;
    int unsigned cpu_rate, dma_rate;
    bit          cpu_seen, dma_seen;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        next_arb      = 0;
        last_arb      = -10;
        m_prio        = 1'b0;
        exp_cpu_rdata = 16'h0000;
        exp_dma_rdata = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            e_cgnt[i] = 1'b0;
            e_dgnt[i] = 1'b0;
            e_en[i]   = 1'b0;
            d_v[i]    = 1'b0;
        end
    endtask

    // Called at each rising edge with rst_n=1: one access may start every other cycle.
    task automatic model_step();
        logic [2:0]  s, d;
        bit          cw, we;
        logic [15:0] a, wd, data;
        if (cyc < next_arb || !(cpu_req || dma_req)) return;
        cw = cpu_req && (!dma_req || !m_prio);
        we = cw ? cpu_we : dma_we;
        a  = cw ? cpu_addr : dma_addr;
        wd = cw ? cpu_wdata : dma_wdata;
        s  = 3'(cyc);
        d  = 3'(cyc + 2);
        e_cgnt[s]  = cw;
        e_dgnt[s]  = !cw;
        e_en[s]    = 1'b1;
        e_we[s]    = we;
        e_addr[s]  = a;
        e_wdata[s] = wd;
        if (we) begin
            ref_mem[a] = wd;
            ref_wr[a]  = 1'b1;
            data       = 16'h0000;
        end else begin
            data = ref_wr[a] ? ref_mem[a] : init_val(a);
        end
        d_v[d]    = 1'b1;
        d_dma[d]  = !cw;
        d_rd[d]   = !we;
        d_data[d] = data;
        m_prio    = cw;
        next_arb  = cyc + 2;
        last_arb  = cyc;
    endtask

    task automatic check_cycle();
        logic [2:0] s;
        s = 3'(cyc);
        if (d_v[s] && d_rd[s]) begin
            if (d_dma[s]) exp_dma_rdata = d_data[s];
            else          exp_cpu_rdata = d_data[s];
        end
        check_eq("cpu_gnt",   16'(cpu_gnt),  16'(e_cgnt[s]));
        check_eq("dma_gnt",   16'(dma_gnt),  16'(e_dgnt[s]));
        check_eq("cpu_done",  16'(cpu_done), 16'(d_v[s] && !d_dma[s]));
        check_eq("dma_done",  16'(dma_done), 16'(d_v[s] && d_dma[s]));
        check_eq("cpu_rdata", cpu_rdata, exp_cpu_rdata);
        check_eq("dma_rdata", dma_rdata, exp_dma_rdata);
        check_eq("mem_en",    16'(mem_en),   16'(e_en[s]));
        if (e_en[s]) begin
            check_eq("mem_we",    16'(mem_we), 16'(e_we[s]));
            check_eq("mem_addr",  mem_addr,  e_addr[s]);
            check_eq("mem_wdata", mem_wdata, e_wdata[s]);
        end
        check_eq("busy", 16'(busy), 16'(cyc == last_arb || cyc == last_arb + 1));
        e_cgnt[s] = 1'b0;
        e_dgnt[s] = 1'b0;
        e_en[s]   = 1'b0;
        d_v[s]    = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_cpu_gnt",   16'(cpu_gnt),  16'h0);
        check_eq("rst_dma_gnt",   16'(dma_gnt),  16'h0);
        check_eq("rst_cpu_done",  16'(cpu_done), 16'h0);
        check_eq("rst_dma_done",  16'(dma_done), 16'h0);
        check_eq("rst_mem_en",    16'(mem_en),   16'h0);
        check_eq("rst_mem_we",    16'(mem_we),   16'h0);
        check_eq("rst_busy",      16'(busy),     16'h0);
        check_eq("rst_mem_addr",  mem_addr,  16'h0000);
        check_eq("rst_mem_wdata", mem_wdata, 16'h0000);
        check_eq("rst_cpu_rdata", cpu_rdata, 16'h0000);
        check_eq("rst_dma_rdata", dma_rdata, 16'h0000);
    endtask

    // Requesters hold their request until a grant is seen, then maybe start another.
    task automatic drive_update();
        if (cpu_seen) cpu_req = 1'b0;
        if (dma_seen) dma_req = 1'b0;
        if (!cpu_req && $urandom_range(99) < cpu_rate) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'($urandom_range(1));
            cpu_addr  = 16'($urandom_range(63));
            cpu_wdata = 16'($urandom);
        end
        if (!dma_req && $urandom_range(99) < dma_rate) begin
            dma_req   = 1'b1;
            dma_we    = 1'($urandom_range(1));
            dma_addr  = 16'($urandom_range(63));
            dma_wdata = 16'($urandom);
        end
    endtask

    task automatic set_cpu(input bit we, input logic [15:0] a, input logic [15:0] wd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_seen = 1'b0;
    endtask

    task automatic set_dma(input bit we, input logic [15:0] a, input logic [15:0] wd);
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd; dma_seen = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            if (rst_n) model_step();
            #1;
            drive_update();
            @(negedge clk);
            if (rst_n) check_cycle();
            else       check_reset_outputs();
            cpu_seen = cpu_gnt;
            dma_seen = dma_gnt;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        cpu_rate = 0;
        dma_rate = 0;
        cpu_seen = 1'b0;
        dma_seen = 1'b0;
        cpu_req  = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        dma_req  = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        run_cycles(3);

        // Simultaneous requests straight out of reset: CPU first.
        set_cpu(1'b0, 16'h0040, 16'h0000);
        set_dma(1'b1, 16'h0041, 16'hCAFE);
        rst_n = 1'b1;
        run_cycles(8);

        // CPU read alone.
        set_cpu(1'b0, 16'h0010, 16'h0000);
        run_cycles(6);
        check_eq("cpu_read_beef", cpu_rdata, 16'hBEEF);

        // DMA write alone.
        set_dma(1'b1, 16'h0200, 16'h1234);
        run_cycles(6);
        check_eq("dma_write_mem", dev_mem[16'h0200], 16'h1234);

        // Both requesters saturating the port.
        cpu_rate = 100;
        dma_rate = 100;
        run_cycles(17);
        cpu_rate = 0;
        dma_rate = 0;
        run_cycles(6);

        // DMA arrives during the CPU's ISSUE cycle and reads what the CPU wrote.
        set_cpu(1'b1, 16'h0005, 16'h7777);
        run_cycles(1);
        set_dma(1'b0, 16'h0005, 16'h0000);
        run_cycles(6);
        check_eq("dma_read_after_cpu_write", dma_rdata, 16'h7777);

        cpu_rate = 40;
        dma_rate = 40;
        run_cycles(300);
        cpu_rate = 0;
        dma_rate = 0;
        run_cycles(6);

        // Reset during DATA of a CPU read abandons the access.
        set_cpu(1'b0, 16'h0020, 16'h0000);
        run_cycles(2);
        set_dma(1'b1, 16'h0021, 16'hA1A1);
        rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs();
        run_cycles(3);
        rst_n = 1'b1;
        run_cycles(8);

        cpu_rate = 30;
        dma_rate = 60;
        run_cycles(200);
        cpu_rate = 0;
        dma_rate = 0;
        run_cycles(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
